// File: rtl/zion_riscv_addsub_pkg.sv
// Shared types for the RV32 add/sub issue/writeback sequencer.
package zion_riscv_addsub_pkg;

    localparam int XLEN = 32;
    localparam int RAW  = 5;

    // Operation select presented to the external add/sub unit
    localparam logic [1:0] EX_OP_IDLE = 2'b00;
    localparam logic [1:0] EX_OP_ADD  = 2'b01;
    localparam logic [1:0] EX_OP_SUB  = 2'b10;

    typedef enum logic [2:0] {
        ALU_F3_ADD  = 3'b000,
        ALU_F3_SLT  = 3'b010,
        ALU_F3_SLTU = 3'b011
    } alu_f3_e;

    typedef enum logic [2:0] {
        BR_F3_BEQ  = 3'b000,
        BR_F3_BNE  = 3'b001,
        BR_F3_BLT  = 3'b100,
        BR_F3_BGE  = 3'b101,
        BR_F3_BLTU = 3'b110,
        BR_F3_BGEU = 3'b111
    } br_f3_e;

    // Branch outcome is derived from the subtract result and the less-than flag
    typedef enum logic [1:0] {
        COND_EQ = 2'd0,
        COND_NE = 2'd1,
        COND_LT = 2'd2,
        COND_GE = 2'd3
    } br_cond_e;

    typedef struct packed {
        logic [1:0]      op;
        logic            uns;
        logic [XLEN-1:0] s1;
        logic [XLEN-1:0] s2;
        logic [RAW-1:0]  rd;
        logic            br;
        br_cond_e        cond;
        logic            slt;
        logic            err;
    } dec_req_t;

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic [RAW-1:0]  rd;
        logic            br;
        logic            taken;
        logic            err;
    } wb_rec_t;

    function automatic logic br_taken(input br_cond_e cond, input logic zero, input logic lt);
        logic t;
        case (cond)
            COND_EQ: t = zero;
            COND_NE: t = !zero;
            COND_LT: t = lt;
            default: t = !lt;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/zion_riscv_addsub_dec.sv
// Combinational decoder: raw request fields -> decoded issue record.
module zion_riscv_addsub_dec
    import zion_riscv_addsub_pkg::*;
(
    input  logic [2:0]      funct3_i,
    input  logic            f7b5_i,
    input  logic            is_imm_i,
    input  logic            is_br_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [RAW-1:0]  rd_i,
    output dec_req_t        dec_o
);

    // Decode funct3/funct7 into exec op, compare mode and writeback kind
    always_comb begin
        dec_o      = '0;
        dec_o.op   = EX_OP_SUB;
        dec_o.s1   = rs1_i;
        dec_o.br   = is_br_i;
        dec_o.cond = COND_EQ;
        if (is_br_i) begin
            // Branches always compare the two registers; rd is meaningless
            dec_o.s2 = rs2_i;
            dec_o.rd = '0;
            case (funct3_i)
                BR_F3_BEQ:  dec_o.cond = COND_EQ;
                BR_F3_BNE:  dec_o.cond = COND_NE;
                BR_F3_BLT:  dec_o.cond = COND_LT;
                BR_F3_BGE:  dec_o.cond = COND_GE;
                BR_F3_BLTU: begin
                    dec_o.cond = COND_LT;
                    dec_o.uns  = 1'b1;
                end
                BR_F3_BGEU: begin
                    dec_o.cond = COND_GE;
                    dec_o.uns  = 1'b1;
                end
                default:    dec_o.err = 1'b1;
            endcase
        end else begin
            dec_o.s2 = is_imm_i ? imm_i : rs2_i;
            dec_o.rd = rd_i;
            case (funct3_i)
                ALU_F3_ADD:  dec_o.op  = (f7b5_i && !is_imm_i) ? EX_OP_SUB : EX_OP_ADD;
                ALU_F3_SLT:  dec_o.slt = 1'b1;
                ALU_F3_SLTU: begin
                    dec_o.slt = 1'b1;
                    dec_o.uns = 1'b1;
                end
                default:     dec_o.err = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/zion_riscv_addsub_issue.sv
// Two-stage issue/writeback sequencer around an external combinational add/sub unit.
// S1 holds the decoded request and drives the exec inputs; S2 holds the writeback record.
// CPU_WIDTH/REG_AW must match the package widths used by the record types.
module zion_riscv_addsub_issue
    import zion_riscv_addsub_pkg::*;
#(
    parameter int CPU_WIDTH = XLEN,
    parameter int REG_AW    = RAW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_vld,
    output logic                 req_rdy,
    input  logic [2:0]           req_funct3,
    input  logic                 req_f7b5,
    input  logic                 req_is_imm,
    input  logic                 req_is_br,
    input  logic [CPU_WIDTH-1:0] req_rs1,
    input  logic [CPU_WIDTH-1:0] req_rs2,
    input  logic [CPU_WIDTH-1:0] req_imm,
    input  logic [REG_AW-1:0]    req_rd,
    output logic [CPU_WIDTH-1:0] ex_s1,
    output logic [CPU_WIDTH-1:0] ex_s2,
    output logic [1:0]           ex_op,
    output logic                 ex_unsigned,
    input  logic [CPU_WIDTH-1:0] ex_rslt,
    input  logic                 ex_lt,
    output logic                 wb_vld,
    input  logic                 wb_rdy,
    output logic [CPU_WIDTH-1:0] wb_data,
    output logic [REG_AW-1:0]    wb_rd,
    output logic                 wb_br,
    output logic                 wb_taken,
    output logic                 wb_err
);

    dec_req_t dec;
    dec_req_t s1_q, s1_d;
    logic     s1_vld_q, s1_vld_d;
    wb_rec_t  s2_q, s2_d;
    logic     s2_vld_q, s2_vld_d;
    wb_rec_t  s2_cap;
    logic     s2_adv;
    logic     s1_adv;
    logic     accept;

    zion_riscv_addsub_dec u_dec (
        .funct3_i (req_funct3),
        .f7b5_i   (req_f7b5),
        .is_imm_i (req_is_imm),
        .is_br_i  (req_is_br),
        .rs1_i    (req_rs1),
        .rs2_i    (req_rs2),
        .imm_i    (req_imm),
        .rd_i     (req_rd),
        .dec_o    (dec)
    );

    // Handshake: S2 frees when empty or drained; S1 frees when it moves into S2
    always_comb begin
        s2_adv  = !s2_vld_q || wb_rdy;
        s1_adv  = s1_vld_q && s2_adv;
        req_rdy = !s1_vld_q || s1_adv;
        accept  = req_vld && req_rdy;
    end

    // Build the writeback record from the S1 request and the exec results
    always_comb begin
        s2_cap       = '0;
        s2_cap.rd    = s1_q.rd;
        s2_cap.br    = s1_q.br;
        s2_cap.err   = s1_q.err;
        s2_cap.taken = s1_q.br && !s1_q.err && br_taken(s1_q.cond, (ex_rslt == '0), ex_lt);
        if (!s1_q.err && !s1_q.br) begin
            s2_cap.data = s1_q.slt ? {{(XLEN-1){1'b0}}, ex_lt} : ex_rslt;
        end
    end

    // Next-state for both stages; a stage that empties is cleared so idle outputs read zero
    always_comb begin
        s1_vld_d = s1_vld_q;
        s1_d     = s1_q;
        s2_vld_d = s2_vld_q;
        s2_d     = s2_q;
        if (accept) begin
            s1_vld_d = 1'b1;
            s1_d     = dec;
        end else if (s1_adv) begin
            s1_vld_d = 1'b0;
            s1_d     = '0;
        end
        if (s2_adv) begin
            s2_vld_d = s1_vld_q;
            s2_d     = s1_vld_q ? s2_cap : '0;
        end
    end

    // Stage registers; reset discards anything in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s1_q     <= '0;
            s2_vld_q <= 1'b0;
            s2_q     <= '0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s1_q     <= s1_d;
            s2_vld_q <= s2_vld_d;
            s2_q     <= s2_d;
        end
    end

    // Exec and writeback outputs come straight from the stage registers
    always_comb begin
        ex_op       = s1_q.op;
        ex_s1       = s1_q.s1;
        ex_s2       = s1_q.s2;
        ex_unsigned = s1_q.uns;
        wb_vld      = s2_vld_q;
        wb_data     = s2_q.data;
        wb_rd       = s2_q.rd;
        wb_br       = s2_q.br;
        wb_taken    = s2_q.taken;
        wb_err      = s2_q.err;
    end

endmodule
